seq_alu_acc: RTL and testbench

- Parametrised sequential successor of the team's 8-bit accumulator ALU.
- Adds a valid/ready command handshake, variable-amount shifts and rotates, carry-chained add/subtract, and a multi-cycle shift-add multiplier.
- Maintains a full status-flag register (C/Z/N/V).
- Sits between the datapath controller and the accumulator consumers; either operand can be replaced by the accumulator.

---
 rtl/seq_alu_acc.sv | 233 +++++++++++++++++++++++
 tb/tb_seq_alu_acc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_acc.sv
// Sequential accumulator ALU: valid/ready command input, single-cycle ALU ops,
// multi-cycle shift-add multiplier and a registered C/Z/N/V status register.
module seq_alu_acc #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             sel_a,
    input  logic             sel_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_ADC  = 4'd8;
    localparam logic [3:0] OP_SBC  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
    localparam logic [3:0] OP_CLR  = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] op_a, op_b, add_b;
    logic [SHW-1:0]   sh;
    logic [SHW:0]     rot_inv;
    logic             add_cin, add_v;
    logic [WIDTH:0]   add_sum, shl_w, shr_w, asr_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             accept;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign acc       = acc_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;
    assign busy      = busy_q;

    always_comb begin
        op_a    = sel_a ? acc_q : a;
        op_b    = sel_b ? acc_q : b;
        sh      = op_b[SHW-1:0];
        rot_inv = (SHW+1)'(WIDTH) - {1'b0, sh};
        add_b   = op_b;
        add_cin = 1'b0;
        case (op)
            OP_SUB:  begin add_b = ~op_b; add_cin = 1'b1;     end
            OP_ADC:  begin add_b = op_b;  add_cin = flag_c_q; end
            OP_SBC:  begin add_b = ~op_b; add_cin = flag_c_q; end
            default: begin add_b = op_b;  add_cin = 1'b0;     end
        endcase
        add_sum = {1'b0, op_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        add_v   = (op_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
        // A guard bit on the shifted-out side captures the last bit lost as carry.
        shl_w   = {1'b0, op_a} << sh;
        shr_w   = {op_a, 1'b0} >> sh;
        asr_w   = $signed({op_a, 1'b0}) >>> sh;

        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = add_v;
            end
            OP_SHL:  begin alu_res = shl_w[WIDTH-1:0]; alu_c = shl_w[WIDTH]; end
            OP_SHR:  begin alu_res = shr_w[WIDTH:1];   alu_c = shr_w[0];     end
            OP_ASR:  begin alu_res = asr_w[WIDTH:1];   alu_c = asr_w[0];     end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOT:  alu_res = ~op_a;
            OP_ROL:  alu_res = (op_a << sh) | (op_a >> rot_inv);
            OP_ROR:  alu_res = (op_a >> sh) | (op_a << rot_inv);
            OP_CLR:  alu_res = '0;
            OP_PASS: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // One shift-add iteration: conditionally add the multiplicand to the high
    // half, then shift the whole {carry, hi, lo} product right by one.
    always_comb begin
        step_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
        mul_hi   = step_sum[WIDTH:1];
        mul_lo   = {step_sum[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        acc_d       = acc_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_v_d    = flag_v_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mcand_d = op_a;
                        lo_d    = op_b;
                        hi_d    = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                        busy_d  = 1'b1;
                    end else begin
                        result_d    = alu_res;
                        acc_d       = alu_res;
                        result_hi_d = '0;
                        flag_c_d    = alu_c;
                        flag_z_d    = (alu_res == '0);
                        flag_n_d    = alu_res[WIDTH-1];
                        flag_v_d    = alu_v;
                        out_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d    = mul_lo;
                    result_hi_d = mul_hi;
                    acc_d       = mul_lo;
                    flag_c_d    = (mul_hi != '0);
                    flag_z_d    = ({mul_hi, mul_lo} == '0);
                    flag_n_d    = mul_hi[WIDTH-1];
                    flag_v_d    = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            acc_q       <= '0;
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            acc_q       <= acc_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_alu_acc.sv
// Directed bench for seq_alu_acc (WIDTH=8): one task per scenario, hand-computed
// expectations; flags are compared as {C,Z,N,V}.
module tb_seq_alu_acc;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       op = 4'd0;
    logic             sel_a = 1'b0;
    logic             sel_b = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic [WIDTH-1:0] result, result_hi, acc;
    logic             flag_c, flag_z, flag_n, flag_v;
    logic             busy;

    int errors = 0;
    int checks = 0;

    seq_alu_acc #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sel_a(sel_a), .sel_b(sel_b), .a(a), .b(b),
        .out_valid(out_valid), .result(result), .result_hi(result_hi), .acc(acc),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid)
            $display("txn: result=0x%02h result_hi=0x%02h acc=0x%02h CZNV=%b%b%b%b",
                     result, result_hi, acc, flag_c, flag_z, flag_n, flag_v);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [3:0] o, input logic sa, input logic sb,
                         input logic [7:0] va, input logic [7:0] vb);
        op = o; sel_a = sa; sel_b = sb; a = va; b = vb; in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++;
        if ({in_ready, out_valid, busy, result, result_hi, acc, flag_c, flag_z, flag_n, flag_v} !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b busy=%b res=%h hi=%h acc=%h flags=%b%b%b%b, want all 0",
                     in_ready, out_valid, busy, result, result_hi, acc, flag_c, flag_z, flag_n, flag_v);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        drive(4'd0, 0, 0, 8'd15, 8'd181); step();
        checks++;
        if ({out_valid, result, flag_c, flag_z, flag_n, flag_v} !== {1'b1, 8'd196, 4'b0010}) begin
            errors++; $display("FAIL add_15_181: ov=%b res=%0d cznv=%b%b%b%b want ov=1 res=196 cznv=0010",
                               out_valid, result, flag_c, flag_z, flag_n, flag_v);
        end
        in_valid = 1'b0; step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL add_pulse_width: out_valid=%b want 0", out_valid);
        end
        drive(4'd0, 0, 0, 8'd200, 8'd100); step();
        checks++;
        if ({out_valid, result, flag_c, flag_z, flag_n, flag_v} !== {1'b1, 8'd44, 4'b1000}) begin
            errors++; $display("FAIL add_200_100: ov=%b res=%0d cznv=%b%b%b%b want ov=1 res=44 cznv=1000",
                               out_valid, result, flag_c, flag_z, flag_n, flag_v);
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_sub();
        drive(4'd1, 0, 0, 8'd10, 8'd10); step();
        checks++;
        if ({result, flag_c, flag_z, flag_n, flag_v} !== {8'd0, 4'b1100}) begin
            errors++; $display("FAIL sub_10_10: res=%0d cznv=%b%b%b%b want res=0 cznv=1100",
                               result, flag_c, flag_z, flag_n, flag_v);
        end
        drive(4'd1, 0, 0, 8'd24, 8'd150); step();
        checks++;
        if ({result, flag_c, flag_z, flag_n, flag_v} !== {8'd130, 4'b0011}) begin
            errors++; $display("FAIL sub_24_150: res=%0d cznv=%b%b%b%b want res=130 cznv=0011",
                               result, flag_c, flag_z, flag_n, flag_v);
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_carry_chain();
        drive(4'd0, 0, 0, 8'd255, 8'd1); step();
        checks++;
        if ({result, flag_c, flag_z, flag_n, flag_v} !== {8'd0, 4'b1100}) begin
            errors++; $display("FAIL chain_add_255_1: res=%0d cznv=%b%b%b%b want res=0 cznv=1100",
                               result, flag_c, flag_z, flag_n, flag_v);
        end
        drive(4'd8, 0, 0, 8'd0, 8'd0); step();
        checks++;
        if ({out_valid, result, flag_c, flag_z, flag_n, flag_v} !== {1'b1, 8'd1, 4'b0000}) begin
            errors++; $display("FAIL chain_adc: ov=%b res=%0d cznv=%b%b%b%b want ov=1 res=1 cznv=0000",
                               out_valid, result, flag_c, flag_z, flag_n, flag_v);
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_mul();
        drive(4'd13, 0, 0, 8'd200, 8'd11); step();
        // The next command is held from here on; it must wait out the multiply.
        drive(4'd15, 0, 0, 8'd0, 8'd77);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({in_ready, out_valid, busy} !== 3'b001) begin
                errors++; $display("FAIL mul_busy_cycle%0d: rdy/ov/busy=%b%b%b want 001",
                                   i, in_ready, out_valid, busy);
            end
            step();
        end
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b110) begin
            errors++; $display("FAIL mul_done_handshake: rdy/ov/busy=%b%b%b want 110",
                               in_ready, out_valid, busy);
        end
        checks++;
        if ({result_hi, result, acc, flag_c, flag_z, flag_n, flag_v} !== {8'd8, 8'd152, 8'd152, 4'b1000}) begin
            errors++; $display("FAIL mul_200_11: hi=%0d res=%0d acc=%0d cznv=%b%b%b%b want hi=8 res=152 acc=152 cznv=1000",
                               result_hi, result, acc, flag_c, flag_z, flag_n, flag_v);
        end
        step();
        checks++;
        if ({out_valid, result, result_hi, acc, flag_c, flag_z, flag_n, flag_v} !== {1'b1, 8'd77, 8'd0, 8'd77, 4'b0000}) begin
            errors++; $display("FAIL mul_held_pass: ov=%b res=%0d hi=%0d acc=%0d cznv=%b%b%b%b want ov=1 res=77 hi=0 acc=77 cznv=0000",
                               out_valid, result, result_hi, acc, flag_c, flag_z, flag_n, flag_v);
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_back_to_back();
        drive(4'd0, 0, 0, 8'd10, 8'd5); step();
        checks++;
        if ({result, acc, flag_c, flag_z, flag_n, flag_v} !== {8'd15, 8'd15, 4'b0000}) begin
            errors++; $display("FAIL b2b_first: res=%0d acc=%0d cznv=%b%b%b%b want 15 15 0000",
                               result, acc, flag_c, flag_z, flag_n, flag_v);
        end
        drive(4'd0, 1, 0, 8'd0, 8'd127); step();
        checks++;
        if ({result, acc, flag_c, flag_z, flag_n, flag_v} !== {8'd142, 8'd142, 4'b0011}) begin
            errors++; $display("FAIL b2b_sel_a: res=%0d acc=%0d cznv=%b%b%b%b want 142 142 0011",
                               result, acc, flag_c, flag_z, flag_n, flag_v);
        end
        drive(4'd0, 1, 1, 8'd0, 8'd0); step();
        checks++;
        if ({out_valid, result, acc, flag_c, flag_z, flag_n, flag_v} !== {1'b1, 8'd28, 8'd28, 4'b1001}) begin
            errors++; $display("FAIL b2b_sel_ab: ov=%b res=%0d acc=%0d cznv=%b%b%b%b want 1 28 28 1001",
                               out_valid, result, acc, flag_c, flag_z, flag_n, flag_v);
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_shifts();
        logic [3:0] ops  [7] = '{4'd2,  4'd2,  4'd3,  4'd10, 4'd11, 4'd14, 4'd12};
        logic [7:0] va   [7] = '{8'h81, 8'h81, 8'h81, 8'h80, 8'h81, 8'h5A, 8'h01};
        logic [7:0] vb   [7] = '{8'd1,  8'd0,  8'd1,  8'd3,  8'd1,  8'd9,  8'd1};
        logic [7:0] wres [7] = '{8'h02, 8'h81, 8'h40, 8'hF0, 8'h03, 8'h00, 8'h80};
        logic [3:0] wfl  [7] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0100, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], 0, 0, va[i], vb[i]); step();
            checks++;
            if ({result, flag_c, flag_z, flag_n, flag_v} !== {wres[i], wfl[i]}) begin
                errors++; $display("FAIL shift_vec%0d op=%0d: res=0x%02h cznv=%b%b%b%b want res=0x%02h cznv=%b",
                                   i, ops[i], result, flag_c, flag_z, flag_n, flag_v, wres[i], wfl[i]);
            end
        end
        in_valid = 1'b0; step();
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        drive(4'd13, 0, 0, 8'd3, 8'd5); step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, result, result_hi, acc, flag_c, flag_z, flag_n, flag_v} !== '0) begin
            errors++; $display("FAIL mid_mul_reset: rdy=%b ov=%b busy=%b res=%h hi=%h acc=%h flags=%b%b%b%b want all 0",
                               in_ready, out_valid, busy, result, result_hi, acc, flag_c, flag_z, flag_n, flag_v);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL post_reset_ready: rdy/busy=%b%b want 10", in_ready, busy);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL aborted_mul_pulse: out_valid pulses=%0d want 0", pulses);
        end
        drive(4'd0, 0, 0, 8'd1, 8'd2); step();
        checks++;
        if ({out_valid, result, acc} !== {1'b1, 8'd3, 8'd3}) begin
            errors++; $display("FAIL post_reset_add: ov=%b res=%0d acc=%0d want 1 3 3", out_valid, result, acc);
        end
        in_valid = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_carry_chain();
        test_mul();
        test_back_to_back();
        test_shifts();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
